// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - valid/ready data bus between the load/store unit and memory.
interface load_store_unit_if;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32 memory-stage load/store unit: one bus transaction per access.
// Optional misalignment faulting is enabled by defining LSU_MISALIGN_EN.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic                     req_write,
    input  logic [2:0]               funct3,
    input  logic [31:0]              addr,
    input  logic [31:0]              wdata,
    output logic                     stall,
    output logic                     done,
    output logic [31:0]              rdata,
    output logic                     fault,
    output logic [31:0]              fault_addr,
    load_store_unit_if.master        bus
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic        bus_valid_q, bus_valid_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_wstrb_q, bus_wstrb_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [15:0] wait_q, wait_d;

    logic        is_byte, is_half, misaligned;
    logic [3:0]  req_strb;
    logic [31:0] req_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        is_byte = (funct3 == 3'b000) || (funct3 == 3'b100);
        is_half = (funct3 == 3'b001) || (funct3 == 3'b101);
`ifdef LSU_MISALIGN_EN
        misaligned = (is_half && addr[0]) || (!is_byte && !is_half && (addr[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
        if (is_byte) begin
            req_strb  = 4'b0001 << addr[1:0];
            req_wdata = {4{wdata[7:0]}};
        end else if (is_half) begin
            req_strb  = addr[1] ? 4'b1100 : 4'b0011;
            req_wdata = {2{wdata[15:0]}};
        end else begin
            req_strb  = 4'hF;
            req_wdata = wdata;
        end
    end

    // Extraction uses the captured request, since the pipeline inputs may move on after RESP.
    always_comb begin
        ld_byte = bus.bus_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = bus.bus_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        bus_valid_d  = bus_valid_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wstrb_d  = bus_wstrb_q;
        bus_wdata_d  = bus_wdata_q;
        done_d       = 1'b0;
        fault_d      = 1'b0;
        rdata_d      = rdata_q;
        fault_addr_d = fault_addr_q;
        addr_d       = addr_q;
        funct3_d     = funct3_q;
        wait_d       = wait_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (misaligned) begin
                        state_d      = S_RESP;
                        done_d       = 1'b1;
                        fault_d      = 1'b1;
                        rdata_d      = 32'h0;
                        fault_addr_d = addr;
                    end else begin
                        state_d     = S_BUS;
                        bus_valid_d = 1'b1;
                        bus_we_d    = req_write;
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_wstrb_d = req_write ? req_strb : 4'h0;
                        bus_wdata_d = req_write ? req_wdata : 32'h0;
                        addr_d      = addr;
                        funct3_d    = funct3;
                        wait_d      = 16'h0;
                    end
                end
            end
            S_BUS: begin
                if (bus.bus_ready) begin
                    state_d     = S_RESP;
                    bus_valid_d = 1'b0;
                    done_d      = 1'b1;
                    rdata_d     = bus_we_q ? 32'h0 : ld_data;
                end else if ((TIMEOUT_LIM != 16'h0) && (wait_q == TIMEOUT_LIM)) begin
                    state_d      = S_RESP;
                    bus_valid_d  = 1'b0;
                    done_d       = 1'b1;
                    fault_d      = 1'b1;
                    rdata_d      = 32'h0;
                    fault_addr_d = addr_q;
                end else begin
                    wait_d = wait_q + 16'h1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d     = S_IDLE;
                bus_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            bus_valid_q  <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= 32'h0;
            bus_wstrb_q  <= 4'h0;
            bus_wdata_q  <= 32'h0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
            rdata_q      <= 32'h0;
            fault_addr_q <= 32'h0;
            addr_q       <= 32'h0;
            funct3_q     <= 3'b000;
            wait_q       <= 16'h0;
        end else begin
            state_q      <= state_d;
            bus_valid_q  <= bus_valid_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wstrb_q  <= bus_wstrb_d;
            bus_wdata_q  <= bus_wdata_d;
            done_q       <= done_d;
            fault_q      <= fault_d;
            rdata_q      <= rdata_d;
            fault_addr_q <= fault_addr_d;
            addr_q       <= addr_d;
            funct3_q     <= funct3_d;
            wait_q       <= wait_d;
        end
    end

    assign stall         = req_valid && (state_q != S_RESP) && !reset;
    assign done          = done_q;
    assign fault         = fault_q;
    assign rdata         = rdata_q;
    assign fault_addr    = fault_addr_q;
    assign bus.bus_valid = bus_valid_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wstrb = bus_wstrb_q;
    assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized bench for load_store_unit against a transaction-level model.
module tb_load_store_unit;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, done, fault;
    logic [31:0] rdata, fault_addr;

    load_store_unit_if bus_if ();

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .done       (done),
        .rdata      (rdata),
        .fault      (fault),
        .fault_addr (fault_addr),
        .bus        (bus_if)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic chk_en = 1'b0;

    logic        e_stall, e_bv, e_we, e_done, e_fault, e_store;
    logic [31:0] e_addr, e_wdata, e_rdata, e_fa;
    logic [3:0]  e_strb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_is_byte(input logic [2:0] f3);
        return (f3 == 3'd0) || (f3 == 3'd4);
    endfunction

    function automatic logic m_is_half(input logic [2:0] f3);
        return (f3 == 3'd1) || (f3 == 3'd5);
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
        int lane;
        lane = int'(a[1:0]);
        if (m_is_byte(f3)) return 4'(1 << lane);
        if (m_is_half(f3)) return (lane >= 2) ? 4'b1100 : 4'b0011;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (m_is_byte(f3)) return (d & 32'hFF) * 32'h01010101;
        if (m_is_half(f3)) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] b, h;
        b = (d >> (8 * int'(a[1:0]))) & 32'hFF;
        h = (a[1] ? (d >> 16) : d) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd5:    return h;
            default: return d;
        endcase
    endfunction

    function automatic logic m_misal(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_EN
        if (m_is_byte(f3)) return 1'b0;
        if (m_is_half(f3)) return a[0];
        return a[1:0] != 2'b00;
`else
        return (f3 == 3'd7) && (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    task automatic set_exp(input logic s, input logic bv, input logic dn, input logic ft,
                           input logic [31:0] rd, input logic [31:0] fa);
        e_stall = s; e_bv = bv; e_done = dn; e_fault = ft; e_rdata = rd; e_fa = fa;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 32'(stall), 32'(e_stall));
            chk("bus_valid", 32'(bus_if.bus_valid), 32'(e_bv));
            chk("done", 32'(done), 32'(e_done));
            chk("fault", 32'(fault), 32'(e_fault));
            if (e_done) chk("rdata", rdata, e_rdata);
            if (e_done && e_fault) chk("fault_addr", fault_addr, e_fa);
            if (e_bv) begin
                chk("bus_we", 32'(bus_if.bus_we), 32'(e_we));
                chk("bus_addr", bus_if.bus_addr, e_addr);
                chk("bus_wstrb", 32'(bus_if.bus_wstrb), 32'(e_strb));
                if (e_store) chk("bus_wdata", bus_if.bus_wdata, e_wdata);
            end
        end
    end

    // One access from request to the cycle after done; wait states counted before bus_ready.
    task automatic access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input int waits, input logic [31:0] rd);
        logic        mis, to;
        int          n;
        logic [31:0] res;
        mis = m_misal(f3, a);
        to  = (TMO != 0) && (waits > int'(TMO));
        n   = to ? int'(TMO) + 1 : waits + 1;
        res = (to || w) ? 32'h0 : m_load(f3, a, rd);
        req_valid = 1'b1; req_write = w; funct3 = f3; addr = a; wdata = d;
        bus_if.bus_ready = 1'b0; bus_if.bus_rdata = rd;
        e_we = w; e_store = w; e_addr = a & ~32'h3;
        e_strb = w ? m_strb(f3, a) : 4'h0;
        e_wdata = m_wdata(f3, d);
        set_exp(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        if (mis) begin
            step();
            set_exp(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, a);
        end else begin
            for (int c = 1; c <= n; c++) begin
                step();
                bus_if.bus_ready = !to && (c == n);
                set_exp(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
            end
            step();
            bus_if.bus_ready = 1'b0;
            set_exp(1'b0, 1'b0, 1'b1, to, res, a);
        end
        step();
    endtask

    task automatic idle();
        req_valid = 1'b0;
        bus_if.bus_ready = 1'($urandom_range(0, 1));
        bus_if.bus_rdata = $urandom;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
    endtask

    logic [2:0] f3_tab [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; funct3 = 3'd0;
        addr = 32'h0; wdata = 32'h0; bus_if.bus_ready = 1'b0; bus_if.bus_rdata = 32'h0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        e_we = 1'b0; e_store = 1'b0; e_addr = 32'h0; e_wdata = 32'h0; e_strb = 4'h0;
        repeat (2) @(posedge clk);
        req_valid = 1'b1;
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_bus_valid", 32'(bus_if.bus_valid), 32'h0);
        chk("rst_bus_we", 32'(bus_if.bus_we), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_fault", 32'(fault), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_fault_addr", fault_addr, 32'h0);
        chk("rst_bus_addr", bus_if.bus_addr, 32'h0);
        chk("rst_bus_wstrb", 32'(bus_if.bus_wstrb), 32'h0);
        chk("rst_bus_wdata", bus_if.bus_wdata, 32'h0);
        step();
        req_valid = 1'b0;
        reset = 1'b0;
        chk_en = 1'b1;
        idle();

        chk("pin_lb", m_load(3'd0, 32'h103, 32'h80112233), 32'hFFFFFF80);
        chk("pin_lbu", m_load(3'd4, 32'h103, 32'h80112233), 32'h00000080);
        chk("pin_lh", m_load(3'd1, 32'h102, 32'h80112233), 32'hFFFF8011);
        chk("pin_sb_strb", 32'(m_strb(3'd0, 32'h22)), 32'h4);
        chk("pin_sh_strb", 32'(m_strb(3'd1, 32'h22)), 32'hC);
        chk("pin_sb_data", m_wdata(3'd0, 32'h000000AB), 32'hABABABAB);
        chk("pin_sh_data", m_wdata(3'd1, 32'h00001234), 32'h12341234);

        access(1'b0, 3'd2, 32'h104, 32'h0, 0, 32'hDEADBEEF);
        access(1'b0, 3'd0, 32'h103, 32'h0, 3, 32'h80112233);
        access(1'b0, 3'd4, 32'h103, 32'h0, 3, 32'h80112233);
        access(1'b1, 3'd0, 32'h22, 32'h000000AB, 0, 32'h55555555);
        access(1'b1, 3'd1, 32'h22, 32'h00001234, 1, 32'h55555555);
        access(1'b0, 3'd2, 32'h300, 32'h0, 10, 32'h12345678);
        access(1'b0, 3'd2, 32'h304, 32'h0, 0, 32'h0BADF00D);
        access(1'b0, 3'd2, 32'h106, 32'h0, 0, 32'h11223344);
        access(1'b0, 3'd2, 32'h108, 32'h0, int'(TMO), 32'hA5A5A5A5);
        idle();

        chk_en = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; funct3 = 3'd2; addr = 32'h200;
        bus_if.bus_ready = 1'b0; bus_if.bus_rdata = 32'hCAFEF00D;
        step();
        step();
        chk("rstbus_pre_valid", 32'(bus_if.bus_valid), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("rstbus_valid_drop", 32'(bus_if.bus_valid), 32'h0);
        chk("rstbus_stall", 32'(stall), 32'h0);
        step();
        reset = 1'b0;
        req_valid = 1'b0;
        bus_if.bus_ready = 1'b1;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk_en = 1'b1;
        step();
        bus_if.bus_ready = 1'b0;
        step();
        access(1'b0, 3'd2, 32'h204, 32'h0, 1, 32'h87654321);

        for (int i = 0; i < 300; i++) begin
            access(1'($urandom_range(0, 1)), f3_tab[$urandom_range(0, 7)],
                   $urandom & 32'h0000FFFF, $urandom, int'($urandom_range(0, 6)), $urandom);
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) idle();
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
